// File: rtl/vedic_mult_seq32_if.sv
// Operand/result handshake bundle for vedic_mult_seq32.
// master drives operands and result acceptance; slave is the multiplier.
interface vedic_mult_seq32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/vedic_mult_seq32.sv
// 32x32 multiplier built from one shared 16x16 vedic multiplier over four MUL cycles.
// Define VEDIC_SEQ_SIGNED_EN for two's-complement operands; default is unsigned.
module vedic_mult_16bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);
  logic [15:0] ll, lh, hl, hh;
  logic [16:0] mid;

  // Urdhva-tiryagbhyam: vertical products plus the crosswise middle term.
  assign ll  = {8'b0, a_i[7:0]}  * {8'b0, b_i[7:0]};
  assign lh  = {8'b0, a_i[7:0]}  * {8'b0, b_i[15:8]};
  assign hl  = {8'b0, a_i[15:8]} * {8'b0, b_i[7:0]};
  assign hh  = {8'b0, a_i[15:8]} * {8'b0, b_i[15:8]};
  assign mid = {1'b0, lh} + {1'b0, hl};
  assign p_o = {hh, 16'b0} + {7'b0, mid, 8'b0} + {16'b0, ll};
endmodule

module vedic_mult_seq32 #(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  vedic_mult_seq32_if.slave   bus,
  output logic [1:0]          dbg_state_o
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and out/out_valid hold until accepted.
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, FIX = 2'd2, DONE = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] am_q, am_d, bm_q, bm_d;
  logic [63:0] out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] a_mag, b_mag;
  logic        zero_op;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;
  logic [63:0] pp;
  logic [63:0] fix_val;

`ifdef VEDIC_SEQ_SIGNED_EN
  logic neg_q, neg_d;
  assign a_mag   = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
  assign b_mag   = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
  assign fix_val = neg_q ? (~acc_q + 64'd1) : acc_q;
`else
  assign a_mag   = bus.a;
  assign b_mag   = bus.b;
  assign fix_val = acc_q;
`endif

  assign zero_op = (bus.a == 32'd0) || (bus.b == 32'd0);

  // cnt[1] picks the a half, cnt[0] picks the b half.
  assign mul_a = cnt_q[1] ? am_q[31:16] : am_q[15:0];
  assign mul_b = cnt_q[0] ? bm_q[31:16] : bm_q[15:0];

  vedic_mult_16bit u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  always_comb begin
    pp = 64'd0;
    case (cnt_q)
      2'd0:    pp = {32'b0, mul_p};
      2'd1,
      2'd2:    pp = {16'b0, mul_p, 16'b0};
      default: pp = {mul_p, 32'b0};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    am_d        = am_q;
    bm_d        = bm_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
`ifdef VEDIC_SEQ_SIGNED_EN
    neg_d       = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          am_d  = a_mag;
          bm_d  = b_mag;
          acc_d = 64'd0;
          cnt_d = 2'd0;
`ifdef VEDIC_SEQ_SIGNED_EN
          neg_d = bus.a[31] ^ bus.b[31];
`endif
          // Zero skip goes through FIX with acc=0 so out_valid rises one edge later.
          state_d = (ZERO_SKIP && zero_op) ? FIX : MUL;
        end
      end
      MUL: begin
        acc_d = acc_q + pp;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = FIX;
      end
      FIX: begin
        out_d       = fix_val;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= 64'd0;
      cnt_q       <= 2'd0;
      am_q        <= 32'd0;
      bm_q        <= 32'd0;
      out_q       <= 64'd0;
      out_valid_q <= 1'b0;
`ifdef VEDIC_SEQ_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      am_q        <= am_d;
      bm_q        <= bm_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef VEDIC_SEQ_SIGNED_EN
      neg_q       <= neg_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_vedic_mult_seq32.sv
// Scoreboarded random/directed bench for vedic_mult_seq32 against a plain-arithmetic model.
// Honours VEDIC_SEQ_SIGNED_EN the same way the design does.
module tb_vedic_mult_seq32;
  localparam bit ZS = 1'b1;

  // clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vedic_mult_seq32_if bus ();
  logic [1:0] dbg_state;

  vedic_mult_seq32 #(.ZERO_SKIP(ZS)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
`ifdef VEDIC_SEQ_SIGNED_EN
    longint sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return 64'(sx * sy);
`else
    return {32'b0, x} * {32'b0, y};
`endif
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // monitor: one pop per completed output handshake
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%016h expected none", bus.out);
      end else begin
        check64("result", bus.out, exp_q.pop_front());
      end
    end
  end

  // driver: one transaction, bp = cycles of output backpressure
  task automatic send(input logic [31:0] x, input logic [31:0] y, input int bp);
    int lat;
    int exp_lat;
    logic [63:0] held;
    exp_lat = (ZS && (x == 32'd0 || y == 32'd0)) ? 1 : 5;
    bus.out_ready = (bp == 0);
    bus.in_valid  = 1'b1;
    bus.a         = x;
    bus.b         = y;
    check64("in_ready_idle", bus.in_ready, 64'd1);
    exp_q.push_back(model(x, y));
    @(posedge clk); #1;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      check64("in_ready_busy", bus.in_ready, 64'd0);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = $urandom;
      bus.b        = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    check64("latency", 64'(lat), 64'(exp_lat));
    held = bus.out;
    for (int i = 0; i < bp; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = $urandom;
      bus.b        = $urandom;
      @(posedge clk); #1;
      check64("hold_valid", bus.out_valid, 64'd1);
      check64("hold_out", bus.out, held);
      check64("hold_in_ready", bus.in_ready, 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check64("post_valid", bus.out_valid, 64'd0);
    check64("post_busy", bus.busy, 64'd0);
    check64("post_in_ready", bus.in_ready, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;
    int r, bp;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check64("rst_out_valid", bus.out_valid, 64'd0);
    check64("rst_out", bus.out, 64'd0);
    check64("rst_busy", bus.busy, 64'd0);
    check64("rst_in_ready", bus.in_ready, 64'd1);
    rst = 1'b0;

    // directed cases
    send(32'd3, 32'd5, 0);
    send(32'hFFFF_FFFF, 32'h0000_0002, 0);
    send(32'h8000_0000, 32'h8000_0000, 0);
    send(32'h8000_0000, 32'h0000_0001, 0);
    send(32'h0000_0000, 32'h1234_5678, 0);
    send(32'h1234_5678, 32'h9ABC_DEF0, 0);
    send(32'h1234_5678, 32'h0000_0000, 3);
    send(32'hDEAD_BEEF, 32'h0BAD_F00D, 10);

    // reset in the middle of MUL (cnt=2): in-flight result is dropped
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 32'd3;
    bus.b         = 32'd5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check64("midrst_out_valid", bus.out_valid, 64'd0);
    check64("midrst_busy", bus.busy, 64'd0);
    check64("midrst_in_ready", bus.in_ready, 64'd1);
    check64("midrst_out", bus.out, 64'd0);
    rst = 1'b0;
    send(32'd7, 32'd6, 0);

    // randomized
    for (int n = 0; n < 40; n++) begin
      x = $urandom;
      y = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) x = 32'd0;
      if (r == 1) y = 32'd0;
      if (r == 2) x = 32'h8000_0000;
      if (r == 3) y = 32'hFFFF_FFFF;
      bp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      send(x, y, bp);
    end

    repeat (2) @(posedge clk);
    #1;
    check64("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
